// File: rtl/brg_frac_if.sv
// brg_frac_if: host bus, control and tick signals between brg_frac and its host
interface brg_frac_if #(
  parameter int DIV_W = 16,
  parameter int OS_LOG2 = 4
);
  logic [7:0] databus;
  logic [1:0] ioaddr;
  logic iocs;
  logic run;
  logic resync;
  logic brg_en;
  logic brg_full;
  logic [OS_LOG2-1:0] os_phase;
  logic [DIV_W-1:0] div_active;
  modport master (
    output databus, ioaddr, iocs, run, resync,
    input brg_en, brg_full, os_phase, div_active
  );
  modport slave (
    input databus, ioaddr, iocs, run, resync,
    output brg_en, brg_full, os_phase, div_active
  );
endinterface

// File: rtl/brg_frac.sv
// brg_frac: fractional baud-rate generator with shadowed divisor, run gating and resync
module brg_frac #(
  parameter int DIV_W = 16,
  parameter int FRAC_W = 4,
  parameter int OS_LOG2 = 4,
  parameter int RST_DIV = 10401
) (
  input logic clk,
  input logic rst,
  brg_frac_if.slave b
);
  localparam int IW = DIV_W - FRAC_W;
  localparam int AW = (FRAC_W == 0) ? 1 : FRAC_W;
  localparam logic [DIV_W-1:0] RV = DIV_W'(RST_DIV);
  logic [IW:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, frac_sel;
  logic [OS_LOG2-1:0] os_q, os_d;
  logic [DIV_W-1:0] act_q, act_d, shd_q, shd_d, div_sel;
  logic [7:0] lo_q, lo_d;
  logic pend_q, pend_d;
  logic wr_lo, wr_hi, tick, commit;
  logic [IW-1:0] int_sel;
  logic [AW:0] sum;
  always_comb begin
    wr_lo = b.iocs & (b.ioaddr == 2'b10);
    wr_hi = b.iocs & (b.ioaddr == 2'b11);
    div_sel = pend_q ? shd_q : act_q;
    int_sel = div_sel[DIV_W-1:FRAC_W];
    frac_sel = (FRAC_W == 0) ? '0 : div_sel[AW-1:0];
    sum = {1'b0, acc_q} + {1'b0, frac_sel};
    tick = b.run & ~b.resync & (cnt_q == '0);
    commit = pend_q & (b.resync | ~b.run | tick);
    cnt_d = b.resync ? {1'b0, int_sel >> 1}
          : ~b.run ? (pend_q ? {1'b0, int_sel} : cnt_q)
          : tick ? {1'b0, int_sel} + (IW+1)'(sum[AW])
          : cnt_q - (IW+1)'(1);
    acc_d = (b.resync | commit) ? '0 : tick ? sum[AW-1:0] : acc_q;
    os_d = b.resync ? '1 : tick ? os_q - OS_LOG2'(1) : os_q;
    act_d = commit ? shd_q : act_q;
    shd_d = wr_hi ? {b.databus[DIV_W-9:0], lo_q} : shd_q;
    pend_d = wr_hi | (pend_q & ~commit);
    lo_d = wr_lo ? b.databus : lo_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= {1'b0, RV[DIV_W-1:FRAC_W]};
      acc_q <= '0;
      os_q <= '1;
      act_q <= RV;
      shd_q <= RV;
      lo_q <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      os_q <= os_d;
      act_q <= act_d;
      shd_q <= shd_d;
      lo_q <= lo_d;
      pend_q <= pend_d;
    end
  assign b.brg_en = tick;
  assign b.brg_full = tick & (os_q == '0);
  assign b.os_phase = os_q;
  assign b.div_active = act_q;
endmodule
